// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, axis timing record and total-length helper.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    logic        pol;
  } axis_timing_t;

  localparam int unsigned CNT_W_DEFAULT   = 11;
  localparam int unsigned PIX_DIV_DEFAULT = 1;

  // 640x480@60, negative syncs
  localparam axis_timing_t VGA640_H = '{active: 640, front: 16, sync: 96, back: 48, pol: 1'b0};
  localparam axis_timing_t VGA640_V = '{active: 480, front: 10, sync: 2,  back: 33, pol: 1'b0};

  // 800x600@60, positive syncs
  localparam axis_timing_t SVGA800_H = '{active: 800, front: 40, sync: 128, back: 88, pol: 1'b1};
  localparam axis_timing_t SVGA800_V = '{active: 600, front: 1,  sync: 4,   back: 23, pol: 1'b1};

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the generator (master) and a video consumer (slave).
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = vga_timing_pkg::CNT_W_DEFAULT
);
  logic             en;
  logic             pix_ce;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             videoon;
  logic             h_synq;
  logic             v_synq;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output pix_ce, pixel_x, pixel_y, videoon, h_synq, v_synq, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, pixel_x, pixel_y, videoon, h_synq, v_synq, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap, next-state active decode and registered sync.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic             wrap,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             sync
);

  localparam int unsigned      TOTAL    = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACT_END  = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0]   SYNC_BEG = (CNT_W+1)'(ACTIVE + FRONT);
  localparam logic [CNT_W:0]   SYNC_END = (CNT_W+1)'(ACTIVE + FRONT + SYNC);

  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W:0]   count_nxt_w;

  assign wrap = inc && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (inc) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // widened copy so a window ending exactly at 2**CNT_W still compares correctly
  assign count_nxt_w = {1'b0, count_nxt};
  assign active      = count_nxt_w < ACT_END;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      sync  <= (count_nxt_w >= SYNC_BEG && count_nxt_w < SYNC_END) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-clock divider feeding chained horizontal/vertical axis counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA640_H.active,
  parameter int unsigned H_FRONT    = VGA640_H.front,
  parameter int unsigned H_SYNC     = VGA640_H.sync,
  parameter int unsigned H_BACK     = VGA640_H.back,
  parameter int unsigned V_ACTIVE   = VGA640_V.active,
  parameter int unsigned V_FRONT    = VGA640_V.front,
  parameter int unsigned V_SYNC     = VGA640_V.sync,
  parameter int unsigned V_BACK     = VGA640_V.back,
  parameter bit          H_SYNC_POL = VGA640_H.pol,
  parameter bit          V_SYNC_POL = VGA640_V.pol,
  parameter int unsigned PIX_DIV    = PIX_DIV_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned      H_TOTAL  = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned      V_TOTAL  = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  if (H_TOTAL > (2 ** CNT_W)) begin : g_h_total_too_wide
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (2 ** CNT_W)) begin : g_v_total_too_wide
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIX_DIV == 0 || PIX_DIV > 16) begin : g_pix_div_range
    $error("vga_timing_gen: PIX_DIV must be 1..16");
  end

  logic [DIV_W-1:0] div_q;
  logic             ce;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             videoon_q;

  // pixel strobe: last divider phase while running, never during reset
  assign ce = vga.en && !rst && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (vga.en) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (ce),
    .wrap   (h_wrap),
    .count  (vga.pixel_x),
    .active (h_active),
    .sync   (vga.h_synq)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (h_wrap),
    .wrap   (v_wrap),
    .count  (vga.pixel_y),
    .active (v_active),
    .sync   (vga.v_synq)
  );

  // both axis decodes are next-state, so this flop lines up with pixel_x/pixel_y
  always_ff @(posedge clk) begin
    if (rst) begin
      videoon_q <= 1'b1;
    end else begin
      videoon_q <= h_active && v_active;
    end
  end

  assign vga.videoon     = videoon_q;
  assign vga.pix_ce      = ce;
  assign vga.line_start  = ce && (vga.pixel_x == '0);
  assign vga.frame_start = ce && (vga.pixel_x == '0) && (vga.pixel_y == '0);

  a_frame_wrap_on_line_wrap : assert property (@(posedge clk) disable iff (rst) v_wrap |-> h_wrap);

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (visible pixels/line); H_FRONT 16; H_SYNC 96; H_BACK 48 (horizontal periods, in pixels).
REQ-002 SHALL have parameters: V_ACTIVE 480 (visible lines); V_FRONT 10; V_SYNC 2; V_BACK 33 (vertical periods, in lines).
REQ-003 SHALL have parameters: H_SYNC_POL 0 and V_SYNC_POL 0 (asserted sync level); PIX_DIV 1 (clk cycles per pixel, 1..16); CNT_W 11 (coordinate width).
REQ-004 SHALL have ports: clk in 1 (system clock); rst in 1 (reset, one clock; synchronous, active-high).
REQ-005 SHALL have ports: en in 1 (run enable); pix_ce out 1 (pixel strobe); pixel_x out CNT_W; pixel_y out CNT_W.
REQ-006 SHALL have ports: videoon out 1; h_synq out 1; v_synq out 1; line_start out 1; frame_start out 1.

Function
REQ-007 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; both SHALL fit in CNT_W bits, else elaboration error.
REQ-008 Divider counts 0..PIX_DIV-1 on clk while en=1; pix_ce=1 for exactly the clk cycle in which divider = PIX_DIV-1 (PIX_DIV=1: pix_ce=en every cycle).
REQ-009 pixel_x advances by 1 on each clk edge where pix_ce=1; at H_TOTAL-1 it wraps to 0 and pixel_y advances by 1.
REQ-010 pixel_y wraps from V_TOTAL-1 to 0 on the same edge that pixel_x wraps from H_TOTAL-1.
REQ-011 en=0 SHALL freeze divider, pixel_x and pixel_y, and force pix_ce=0; other outputs hold values consistent with the frozen counters.
REQ-012 videoon=1 iff pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
REQ-013 h_synq=H_SYNC_POL iff H_ACTIVE+H_FRONT <= pixel_x < H_ACTIVE+H_FRONT+H_SYNC, else ~H_SYNC_POL.
REQ-014 v_synq=V_SYNC_POL iff V_ACTIVE+V_FRONT <= pixel_y < V_ACTIVE+V_FRONT+V_SYNC, else ~V_SYNC_POL; v_synq SHALL be a function of pixel_y only.
REQ-015 videoon, h_synq and v_synq SHALL be registered, decoded from next-state counters, zero-cycle skew vs pixel_x/pixel_y, glitch-free.
REQ-016 line_start=1 iff pix_ce=1 and pixel_x=0.
REQ-017 frame_start=1 iff pix_ce=1 and pixel_x=0 and pixel_y=0; it SHALL be a one-clk pulse.
REQ-018 Simultaneous wrap of pixel_x and pixel_y SHALL occur in one edge; there SHALL be no intermediate (0,V_TOTAL) or (H_TOTAL,y) state.

Reset
REQ-019 rst=1 on a clk edge SHALL set divider=0, pixel_x=0, pixel_y=0, pix_ce=0, line_start=0, frame_start=0, regardless of en.
REQ-020 During and after reset: videoon=1, h_synq=~H_SYNC_POL, v_synq=~V_SYNC_POL.
REQ-021 Reset mid-frame SHALL restart timing at (0,0); first pix_ce arrives PIX_DIV clk cycles after rst deasserts (en=1) and carries frame_start=1.

Structure
REQ-022 Package vga_timing_pkg SHALL hold the 640x480@60 default constants, an 800x600 constant set, and the H_TOTAL/V_TOTAL derivation function.
REQ-023 Sub-module vga_axis_counter (parametrised ACTIVE/FRONT/SYNC/BACK/POL, inc in, wrap out, count/active/sync out) SHALL be instantiated once per axis; the vertical inc is the horizontal wrap.

Verification
REQ-024 H 4/1/2/1, V 3/1/1/1, PIX_DIV=1, POLs=0, en=1 after rst: pixel_x cycles 0..7; h_synq=0 exactly at x=5,6; v_synq=0 exactly at y=4; frame_start every 48 clk.
REQ-025 Same timing, PIX_DIV=4: pix_ce every 4th clk; pixel_x steps once per 4 clk; first frame_start at clk 4 after rst release.
REQ-026 Defaults: frame length 800*525=420000 pix_ce; videoon high 640*480=307200 pix_ce per frame; h_synq low 96 pixels/line.
REQ-027 Small timing, en dropped at (x=6,y=4) for 10 clk: counters, syncs and videoon hold; pix_ce=0; resumes at x=7 with no skipped pixel.
REQ-028 Small timing, rst pulsed 1 clk at (x=3,y=2): next edge shows (0,0), videoon=1, syncs inactive; next frame_start 1 clk after rst (PIX_DIV=1).
REQ-029 H_SYNC_POL=1, V_SYNC_POL=1: sync waveforms of REQ-024 inverted; videoon and counters unchanged.
